// File: rtl/aemb_ifetch_if.sv
// Instruction-side Wishbone classic bus between the prefetch unit and memory.
// The master drives address and strobe; the slave returns data and acknowledge.
interface aemb_ifetch_if #(
  parameter int AW = 30
);
  logic [AW-1:0] iwb_adr_o;
  logic          iwb_stb_o;
  logic [31:0]   iwb_dat_i;
  logic          iwb_ack_i;

  modport master (
    output iwb_adr_o,
    output iwb_stb_o,
    input  iwb_dat_i,
    input  iwb_ack_i
  );

  modport slave (
    input  iwb_adr_o,
    input  iwb_stb_o,
    output iwb_dat_i,
    output iwb_ack_i
  );
endinterface

// File: rtl/aemb_ifetch.sv
// AEMB instruction prefetch unit: owns the fetch PC, runs one Wishbone
// instruction cycle at a time and buffers returned words in a small FIFO.
// The head entry is presented to the instruction buffer stage.
// Optional feature: define AEMB_IFETCH_BYPASS_EN to let an ack into an empty
// FIFO drive the head outputs combinationally in the ack cycle.
module aemb_ifetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          rBRA,
  input  logic [AW-1:0] rBADR,
  aemb_ifetch_if.master iwb,
  output logic [31:0]   rIDAT,
  output logic [AW-1:0] rIPC,
  output logic          rIVLD
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h80000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          stb_q, stb_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;

  logic [AW-1:0] adrMem [DEPTH];
  logic [31:0]   datMem [DEPTH];

  logic flush;
  logic ackLive;
  logic fifoPop;
  logic consumed;
  logic push;

  assign iwb.iwb_adr_o = adr_q;
  assign iwb.iwb_stb_o = stb_q;

`ifdef AEMB_IFETCH_BYPASS_EN
  logic bypass;
  assign bypass   = ackLive & ~flush & (cnt_q == '0);
  assign consumed = bypass & gena;
`else
  assign consumed = 1'b0;
`endif

  // Push/pop qualification and FIFO occupancy/pointer update; a flush wins.
  always_comb begin
    flush   = gena & rBRA;
    ackLive = iwb.iwb_ack_i & (state_q == BUSY);
    fifoPop = gena & (cnt_q != '0);
    push    = ackLive & ~flush & ~consumed;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      cnt_d  = cnt_q + CW'(push) - CW'(fifoPop);
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(fifoPop);
    end
  end

  // Bus FSM: issue when nothing is outstanding and space remains after this
  // cycle's update; a flush while a cycle is outstanding drains it first.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = BUSY;
          adr_d   = rBADR;
        end else if (cnt_d < FULL) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (iwb.iwb_ack_i) begin
          if (flush) begin
            adr_d = rBADR;
          end else begin
            adr_d   = adr_q + AW'(1);
            state_d = (cnt_d < FULL) ? BUSY : IDLE;
          end
        end else if (flush) begin
          state_d = DRAIN;
          tgt_d   = rBADR;
        end
      end
      DRAIN: begin
        if (iwb.iwb_ack_i) begin
          state_d = BUSY;
          adr_d   = flush ? rBADR : tgt_q;
        end else if (flush) begin
          tgt_d = rBADR;
        end
      end
      default: state_d = IDLE;
    endcase
    stb_d = (state_d != IDLE);
  end

  // Control and address registers with synchronous reset.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // FIFO storage of {address, instruction} pairs; contents need no reset.
  always_ff @(posedge gclk) begin
    if (push) begin
      adrMem[wptr_q] <= adr_q;
      datMem[wptr_q] <= iwb.iwb_dat_i;
    end
  end

  // Head presentation: NOP at address 0 whenever nothing is valid.
  always_comb begin
    rIVLD = 1'b0;
    rIDAT = NOP;
    rIPC  = '0;
    if (cnt_q != '0) begin
      rIVLD = 1'b1;
      rIDAT = datMem[rptr_q];
      rIPC  = adrMem[rptr_q];
    end
`ifdef AEMB_IFETCH_BYPASS_EN
    else if (bypass) begin
      rIVLD = 1'b1;
      rIDAT = iwb.iwb_dat_i;
      rIPC  = adr_q;
    end
`endif
  end

endmodule

// File: tb/tb_aemb_ifetch.sv
// Self-checking bench for aemb_ifetch: random pipeline/branch/ack stimulus,
// a stream-level reference model and a scoreboard of expected deliveries.
// Honours AEMB_IFETCH_BYPASS_EN when the design is built with it.
module tb_aemb_ifetch;

  localparam int DEPTH = 4;
  localparam int AW    = 30;
  localparam logic [31:0] NOP = 32'h80000000;

  typedef struct {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } entry_t;

  logic          gclk = 1'b0;
  logic          grst;
  logic          gena;
  logic          rBRA;
  logic [AW-1:0] rBADR;
  logic [31:0]   rIDAT;
  logic [AW-1:0] rIPC;
  logic          rIVLD;

  aemb_ifetch_if #(.AW(AW)) bus ();

  aemb_ifetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .gclk (gclk),
    .grst (grst),
    .gena (gena),
    .rBRA (rBRA),
    .rBADR(rBADR),
    .iwb  (bus.master),
    .rIDAT(rIDAT),
    .rIPC (rIPC),
    .rIVLD(rIVLD)
  );

  int nChecks = 0;
  int nFails  = 0;
  int ackCount = 0;
  int popCount = 0;
  logic [AW-1:0] lastAckAdr = '0;

  entry_t        expQ[$];
  logic [AW-1:0] nextFetch = '0;
  logic          dropNext = 1'b0;
  logic          prevPending = 1'b0;
  logic [AW-1:0] prevAdr = '0;

  // Free-running clock.
  always #5 gclk = ~gclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge; the slave
  // acknowledges a pending strobe with the given probability and random data.
  task automatic applyStimulus(input logic g, input logic b, input logic [AW-1:0] t, input int ackPct);
    @(posedge gclk);
    #1;
    gena  = g;
    rBRA  = b;
    rBADR = t;
    if (bus.iwb_stb_o && !grst && ($urandom_range(0, 99) < ackPct)) begin
      bus.iwb_ack_i = 1'b1;
      bus.iwb_dat_i = $urandom;
      ackCount++;
      lastAckAdr = bus.iwb_adr_o;
    end else begin
      bus.iwb_ack_i = 1'b0;
      bus.iwb_dat_i = $urandom;
    end
  endtask

  // Monitor/model: at mid-cycle, decide what the coming edge does to the
  // instruction stream and compare the DUT's head against the scoreboard.
  always @(negedge gclk) begin : monitor
    logic ackNow;
    logic flushNow;
    entry_t e;
    if (grst) begin
      expQ.delete();
      nextFetch   = '0;
      dropNext    = 1'b0;
      prevPending = 1'b0;
    end else begin
      ackNow   = bus.iwb_stb_o & bus.iwb_ack_i;
      flushNow = gena & rBRA;
      if (prevPending) begin
        checkOutput("stb_hold", 32'(bus.iwb_stb_o), 32'd1);
        checkOutput("adr_hold", 32'(bus.iwb_adr_o), 32'(prevAdr));
      end
      prevPending = bus.iwb_stb_o & ~bus.iwb_ack_i;
      prevAdr     = bus.iwb_adr_o;
`ifndef AEMB_IFETCH_BYPASS_EN
      checkOutput("ivld", 32'(rIVLD), 32'(expQ.size() != 0));
`endif
      if (ackNow) begin
        if (dropNext) begin
          dropNext = 1'b0;
        end else if (!flushNow) begin
          checkOutput("fetch_adr", 32'(bus.iwb_adr_o), 32'(nextFetch));
          checkOutput("ack_space", 32'(expQ.size() < DEPTH), 32'd1);
          e.adr = bus.iwb_adr_o;
          e.dat = bus.iwb_dat_i;
          expQ.push_back(e);
          nextFetch = nextFetch + AW'(1);
        end
      end
`ifdef AEMB_IFETCH_BYPASS_EN
      checkOutput("ivld", 32'(rIVLD), 32'(expQ.size() != 0));
`endif
      if (!rIVLD) begin
        checkOutput("empty_dat", rIDAT, NOP);
        checkOutput("empty_pc", 32'(rIPC), 32'd0);
      end
      if (gena && rIVLD) begin
        checkOutput("pop_nonempty", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("head_pc", 32'(rIPC), 32'(e.adr));
          checkOutput("head_dat", rIDAT, e.dat);
          popCount++;
        end
      end
      if (flushNow) begin
        expQ.delete();
        nextFetch = rBADR;
        dropNext  = bus.iwb_stb_o & ~bus.iwb_ack_i;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus sequence.
  initial begin
    logic [AW-1:0] tgt;
    grst = 1'b1;
    gena = 1'b0;
    rBRA = 1'b0;
    rBADR = '0;
    bus.iwb_ack_i = 1'b0;
    bus.iwb_dat_i = '0;

    repeat (3) applyStimulus(1'b0, 1'b0, '0, 0);
    @(negedge gclk);
    checkOutput("rst_stb", 32'(bus.iwb_stb_o), 32'd0);
    checkOutput("rst_adr", 32'(bus.iwb_adr_o), 32'd0);
    checkOutput("rst_ivld", 32'(rIVLD), 32'd0);
    checkOutput("rst_dat", rIDAT, NOP);
    checkOutput("rst_pc", 32'(rIPC), 32'd0);

    // Release reset: strobe rises at the following edge with address 0.
    @(posedge gclk);
    #1;
    grst = 1'b0;
    @(negedge gclk);
    checkOutput("first_stb_low", 32'(bus.iwb_stb_o), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 0);
    @(negedge gclk);
    checkOutput("first_stb", 32'(bus.iwb_stb_o), 32'd1);
    checkOutput("first_adr", 32'(bus.iwb_adr_o), 32'd0);

    // Fill with no consumption: exactly DEPTH words accepted, then idle.
    ackCount = 0;
    repeat (12) applyStimulus(1'b0, 1'b0, '0, 100);
    @(negedge gclk);
    checkOutput("fill_acks", 32'(ackCount), 32'(DEPTH));
    checkOutput("fill_stb", 32'(bus.iwb_stb_o), 32'd0);
    checkOutput("fill_ivld", 32'(rIVLD), 32'd1);

    // One pop frees one slot: exactly one more fetch, at address DEPTH.
    applyStimulus(1'b1, 1'b0, '0, 100);
    repeat (8) applyStimulus(1'b0, 1'b0, '0, 100);
    @(negedge gclk);
    checkOutput("pulse_acks", 32'(ackCount), 32'(DEPTH + 1));
    checkOutput("pulse_adr", 32'(lastAckAdr), 32'(DEPTH));
    checkOutput("pulse_stb", 32'(bus.iwb_stb_o), 32'd0);

    // Randomized run: pipeline stalls, branches (some near address wrap)
    // and a slow slave.
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? AW'(30'h3FFFFFFD) : AW'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt,
                    (i < 1500) ? 60 : 90);
    end

    // Reset in the middle of traffic abandons the bus cycle.
    @(posedge gclk);
    #1;
    grst = 1'b1;
    bus.iwb_ack_i = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 0);
    @(negedge gclk);
    checkOutput("midrst_stb", 32'(bus.iwb_stb_o), 32'd0);
    checkOutput("midrst_ivld", 32'(rIVLD), 32'd0);
    @(posedge gclk);
    #1;
    grst = 1'b0;

    // Streaming: every cycle acked and consumed keeps the strobe high.
    repeat (10) applyStimulus(1'b1, 1'b0, '0, 100);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 100);
      @(negedge gclk);
      checkOutput("b2b_stb", 32'(bus.iwb_stb_o), 32'd1);
    end

    checkOutput("liveness", 32'(popCount > 500), 32'd1);
    repeat (2) applyStimulus(1'b0, 1'b0, '0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
